ir_char_rx: RTL and testbench

UART-style serial receiver that sits directly upstream of the car motor controller. Samples the raw IR receiver line, decodes 8N1 characters and counts them. After every CHAR_TARGET characters it drives the active-low `ir_done_n` strobe that the motor controller consumes as its `ir_signal` input: low means the frame is finished and the run timer reloads.

---
 rtl/ir_char_rx.sv | 210 +++++++++++++++++++++
 tb/tb_ir_char_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_char_rx.sv
// ir_char_rx: 8N1 receiver for the IR line that counts characters per frame and drives the
// active-low ir_done_n strobe. Define IR_RX_FRAME_ERR_EN to reject characters with a bad stop bit.

module ir_char_rx #(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 9600,
    parameter int CHAR_TARGET = 10,
    parameter int DONE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ir_rx,
    input  logic       clr,
    output logic       ir_done_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [3:0] char_cnt,
    output logic       frame_err
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam int DW  = $clog2(DONE_CYCLES + 1);

    // Detection happens one cycle after rx_s falls, hence the -2 on the half-bit load.
    localparam logic [TW-1:0] HALF_LOAD = TW'(DIV / 2 - 2);
    localparam logic [TW-1:0] FULL_LOAD = TW'(DIV - 1);
    localparam logic [DW-1:0] DONE_LOAD = DW'(DONE_CYCLES - 1);
    localparam logic [3:0]    LAST_CNT  = 4'(CHAR_TARGET - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            sync1;
    logic            rx_s;
    logic [1:0]      fill;
    logic            armed;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            stop_done;
    logic            tick;
    logic            load_half;
    logic            load_full;
    logic            shift_en;
    logic            stop_samp;
    logic            accept;
    logic            disarm;
    logic            complete;
    logic [DW-1:0]   done_cnt;

    // The synchronizer resets high, so fill marks when rx_s holds a real sample of the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1 <= ir_rx;
            rx_s  <= sync1;
            fill  <= {fill[0], 1'b1};
            if (disarm)
                armed <= 1'b0;
            else if (rx_s && fill[1])
                armed <= 1'b1;
        end
    end

    assign tick = (timer == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n   = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        stop_samp = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !rx_s) begin
                    state_n   = S_START;
                    load_half = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n   = S_DATA;
                        load_full = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    stop_samp = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            stop_done <= 1'b0;
        end else begin
            if (load_half)
                timer <= HALF_LOAD;
            else if (load_full)
                timer <= FULL_LOAD;
            else if (!tick)
                timer <= timer - 1'b1;

            if (load_half)
                bit_cnt <= 3'd0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;

            if (shift_en)
                shift_reg <= {rx_s, shift_reg[7:1]};

            stop_done <= stop_samp;
        end
    end

`ifdef IR_RX_FRAME_ERR_EN
    logic stop_ok;
    logic bad_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_ok   <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            if (stop_samp)
                stop_ok <= rx_s;
            frame_err <= bad_stop;
        end
    end

    assign accept   = stop_done && stop_ok;
    assign bad_stop = stop_done && !stop_ok;
    assign disarm   = stop_samp && !rx_s;
`else
    assign accept    = stop_done;
    assign disarm    = 1'b0;
    assign frame_err = 1'b0;
`endif

    // clr overrides a coinciding accept, which therefore cannot complete a frame.
    assign complete = accept && !clr && (char_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            char_cnt  <= 4'd0;
            ir_done_n <= 1'b1;
            done_cnt  <= '0;
        end else begin
            rx_valid <= accept;
            if (accept)
                rx_data <= shift_reg;

            if (clr)
                char_cnt <= 4'd0;
            else if (accept)
                char_cnt <= complete ? 4'd0 : char_cnt + 4'd1;

            if (complete) begin
                ir_done_n <= 1'b0;
                done_cnt  <= DONE_LOAD;
            end else if (!ir_done_n) begin
                if (done_cnt == '0)
                    ir_done_n <= 1'b1;
                else
                    done_cnt <= done_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ir_char_rx.sv
// Bench for ir_char_rx: serial stimulus driver with a frame/count reference model feeding a
// scoreboard queue; a monitor pops on rx_valid/frame_err and tracks ir_done_n every cycle.

module tb_ir_char_rx;

    localparam int CLK_HZ      = 64;
    localparam int BAUD        = 4;
    localparam int DIV         = CLK_HZ / BAUD;
    localparam int CHAR_TARGET = 3;
    localparam int DONE_CYCLES = 4;
    localparam int ACC_LAT     = 2 + DIV / 2 + 9 * DIV + 1;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        logic [3:0] cnt;
        bit         done;
        int         cyc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ir_rx = 1'b1;
    logic       clr   = 1'b0;
    logic       ir_done_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] char_cnt;
    logic       frame_err;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   model_cnt   = 0;
    int   done_until  = 0;
    bit   mon_en      = 1'b0;
    exp_t q[$];

    ir_char_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .CHAR_TARGET (CHAR_TARGET),
        .DONE_CYCLES (DONE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_rx     (ir_rx),
        .clr       (clr),
        .ir_done_n (ir_done_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .char_cnt  (char_cnt),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_ir_done_n", 32'(ir_done_n), 32'd1);
        check("rst_rx_data",   32'(rx_data),   32'd0);
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_char_cnt",  32'(char_cnt),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
    endtask

    task automatic clear_count();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_char_cnt", 32'(char_cnt), 32'd0);
        model_cnt = 0;
    endtask

    // Frame-level expectation: what the spec says the accept of this character must show.
    task automatic expect_char(input logic [7:0] data, input bit stop_ok, input bit clr_acc);
        exp_t e;
        e.cyc  = cyc + ACC_LAT;
        e.data = data;
        e.done = 1'b0;
`ifdef IR_RX_FRAME_ERR_EN
        e.ferr = !stop_ok;
`else
        e.ferr = 1'b0;
`endif
        if (clr_acc) begin
            model_cnt = 0;
        end else if (!e.ferr) begin
            model_cnt = model_cnt + 1;
            if (model_cnt == CHAR_TARGET) begin
                model_cnt = 0;
                e.done    = 1'b1;
            end
        end
        e.cnt = 4'(model_cnt);
        q.push_back(e);
    endtask

    // Drives one 8N1 character starting right after a rising edge; abort_at >= 0 resets mid-character.
    task automatic send(input logic [7:0] data, input bit stop_ok, input bit clr_acc,
                        input int gap, input int abort_at);
        logic line;
        for (int c = 0; c < 10 * DIV + gap; c++) begin
            @(negedge clk);
            if (c == 0 && abort_at < 0)
                expect_char(data, stop_ok, clr_acc);
            if (c == abort_at) begin
                rst_n = 1'b0;
                ir_rx = 1'b1;
                clr   = 1'b0;
                @(negedge clk);
                check_reset_outputs();
                rst_n     = 1'b1;
                model_cnt = 0;
                return;
            end
            if (c < DIV)
                line = 1'b0;
            else if (c < 9 * DIV)
                line = data[(c - DIV) / DIV];
            else if (c < 9 * DIV + (3 * DIV) / 4)
                line = stop_ok;
            else
                line = 1'b1;
            ir_rx = line;
            clr   = clr_acc && (c == ACC_LAT - 1);
        end
        clr = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t me;
        if (mon_en) begin
            if (rx_valid || frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {30'd0, rx_valid, frame_err}, 32'd0);
                end else begin
                    me = q.pop_front();
                    check("accept_cycle", 32'(cyc), 32'(me.cyc));
                    check("frame_err", 32'(frame_err), 32'(me.ferr));
                    check("rx_valid", 32'(rx_valid), 32'(!me.ferr));
                    if (!me.ferr) begin
                        check("rx_data", 32'(rx_data), 32'(me.data));
                        check("char_cnt", 32'(char_cnt), 32'(me.cnt));
                    end
                    if (me.done)
                        done_until = me.cyc + DONE_CYCLES;
                end
            end
            check("ir_done_n", 32'(ir_done_n), (cyc < done_until) ? 32'd0 : 32'd1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        idle(3);
        check_reset_outputs();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(10);

        // Single character, latency and data.
        send(8'hA5, 1'b1, 1'b0, 20, -1);
        check("cnt_before_clr", 32'(char_cnt), 32'(model_cnt));
        clear_count();

        // Three back-to-back characters complete a frame.
        send(8'h01, 1'b1, 1'b0, 0, -1);
        send(8'h02, 1'b1, 1'b0, 0, -1);
        send(8'h03, 1'b1, 1'b0, 12, -1);

        // Short low glitch, then a real character.
        @(negedge clk);
        ir_rx = 1'b0;
        idle(3);
        ir_rx = 1'b1;
        idle(20);
        send(8'h5A, 1'b1, 1'b0, 10, -1);

        // Line held low through reset release must not start a character.
        @(negedge clk);
        ir_rx = 1'b0;
        rst_n = 1'b0;
        idle(3);
        check_reset_outputs();
        rst_n     = 1'b1;
        model_cnt = 0;
        idle(200);
        ir_rx = 1'b1;
        idle(10);
        send(8'h33, 1'b1, 1'b0, 10, -1);

        // Reset in the middle of the data bits of the second character.
        send(8'h01, 1'b1, 1'b0, 5, -1);
        send(8'h02, 1'b1, 1'b0, 0, 60);
        idle(10);
        send(8'h44, 1'b1, 1'b0, 10, -1);

        // Bad stop bit.
        send(8'hFF, 1'b0, 1'b0, 10, -1);

        // clr coinciding with the accept that would complete the frame.
        clear_count();
        send(8'h11, 1'b1, 1'b0, 3, -1);
        send(8'h22, 1'b1, 1'b0, 3, -1);
        send(8'h33, 1'b1, 1'b1, 10, -1);

        // Randomized characters.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            bit         s_ok;
            bit         c_acc;
            int         g;
            d     = 8'($urandom);
            s_ok  = ($urandom_range(0, 4) != 0);
            c_acc = ($urandom_range(0, 5) == 0);
            g     = s_ok ? int'($urandom_range(0, 10)) : 8 + int'($urandom_range(0, 4));
            send(d, s_ok, c_acc, g, -1);
        end

        for (int i = 0; i < 400 && q.size() != 0; i++)
            @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        idle(DONE_CYCLES + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
